// File: rtl/wide_alu_sequencer_if.sv
// Bundle of the request, ALU-issue and result handshakes between the wide sequencer and its neighbours.
// The slave modport is the sequencer's view; the master modport is the view of the surrounding logic.
interface wide_alu_sequencer_if #(
    parameter int N     = 32,
    parameter int WORDS = 4
);
    logic               in_valid;
    logic               in_ready;
    logic               in_cmd;
    logic [WORDS*N-1:0] in_a;
    logic [WORDS*N-1:0] in_b;
    logic               in_cin;
    logic [N-1:0]       alu_a;
    logic [N-1:0]       alu_b;
    logic               alu_c_in;
    logic [2:0]         alu_op;
    logic [N-1:0]       alu_sum;
    logic               alu_c_out;
    logic               out_valid;
    logic               out_ready;
    logic [WORDS*N-1:0] out_result;
    logic               out_c_out;

    modport slave (
        input  in_valid, in_cmd, in_a, in_b, in_cin, alu_sum, alu_c_out, out_ready,
        output in_ready, alu_a, alu_b, alu_c_in, alu_op, out_valid, out_result, out_c_out
    );

    modport master (
        output in_valid, in_cmd, in_a, in_b, in_cin, alu_sum, alu_c_out, out_ready,
        input  in_ready, alu_a, alu_b, alu_c_in, alu_op, out_valid, out_result, out_c_out
    );
endinterface

// File: rtl/wide_alu_sequencer.sv
// Splits one wide ADD/NOT into N-bit issues to a registered ALU (LSW first, carry chained)
// and reassembles the registered results into a wide result with the top-word carry.
//   state   | meaning
//   S_IDLE  | ready for a new operation, ALU inputs parked at zero
//   S_RUN   | issuing word idx, capturing the result of word idx-1
//   S_DRAIN | capturing the last word and the final carry
//   S_DONE  | result offered, held until out_ready
module wide_alu_sequencer #(
    parameter int         N      = 32,
    parameter int         WORDS  = 4,
    parameter logic [2:0] OP_ADD = 3'b000,
    parameter logic [2:0] OP_NOT = 3'b001
) (
    input  logic               clk,
    input  logic               rst_n,
    wide_alu_sequencer_if.slave bus
);
    localparam int IW = $clog2(WORDS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [WORDS*N-1:0] a_q, a_d, b_q, b_d;
    logic               cmd_q, cmd_d, cin_q, cin_d;
    logic [WORDS*N-1:0] result_q, result_d;
    logic               c_out_q, c_out_d;

    logic               in_ready;
    logic               out_valid;
    logic [N-1:0]       alu_a, alu_b;
    logic               alu_c_in;
    logic [2:0]         alu_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cmd_q    <= 1'b0;
            cin_q    <= 1'b0;
            result_q <= '0;
            c_out_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cmd_q    <= cmd_d;
            cin_q    <= cin_d;
            result_q <= result_d;
            c_out_q  <= c_out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        cmd_d     = cmd_q;
        cin_d     = cin_q;
        result_d  = result_q;
        c_out_d   = c_out_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_c_in  = 1'b0;
        alu_op    = OP_ADD;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    cmd_d   = bus.in_cmd;
                    cin_d   = bus.in_cin;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                alu_a  = a_q[int'(idx_q)*N +: N];
                alu_b  = b_q[int'(idx_q)*N +: N];
                alu_op = cmd_q ? OP_NOT : OP_ADD;
                // Word 0 takes the external carry; later words chain the ALU's registered carry.
                if (!cmd_q) alu_c_in = (idx_q == '0) ? cin_q : bus.alu_c_out;
                if (idx_q != '0) result_d[(int'(idx_q)-1)*N +: N] = bus.alu_sum;
                if (idx_q == IW'(WORDS-1)) state_d = S_DRAIN;
                else                       idx_d   = idx_q + IW'(1);
            end
            S_DRAIN: begin
                result_d[(WORDS-1)*N +: N] = bus.alu_sum;
                c_out_d = cmd_q ? 1'b0 : bus.alu_c_out;
                state_d = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_result = result_q;
    assign bus.out_c_out  = c_out_q;
    assign bus.alu_a      = alu_a;
    assign bus.alu_b      = alu_b;
    assign bus.alu_c_in   = alu_c_in;
    assign bus.alu_op     = alu_op;
endmodule

// File: tb/tb_wide_alu_sequencer.sv
// Self-checking bench: two sequencer instances (8x4 and 32x2), each with a registered ALU model.
module tb_wide_alu_sequencer;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_NOT = 3'b001;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wide_alu_sequencer_if #(.N(8),  .WORDS(4)) if8 ();
    wide_alu_sequencer_if #(.N(32), .WORDS(2)) if32 ();

    wide_alu_sequencer #(.N(8), .WORDS(4), .OP_ADD(OP_ADD), .OP_NOT(OP_NOT))
        u8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    wide_alu_sequencer #(.N(32), .WORDS(2), .OP_ADD(OP_ADD), .OP_NOT(OP_NOT))
        u32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));

    // Downstream registered ALUs (no reset, 1-cycle latency)
    always_ff @(posedge clk) begin
        if (if8.alu_op == OP_NOT) {if8.alu_c_out, if8.alu_sum} <= {1'b0, ~if8.alu_a};
        else {if8.alu_c_out, if8.alu_sum} <= {1'b0, if8.alu_a} + {1'b0, if8.alu_b} + 9'(if8.alu_c_in);
    end
    always_ff @(posedge clk) begin
        if (if32.alu_op == OP_NOT) {if32.alu_c_out, if32.alu_sum} <= {1'b0, ~if32.alu_a};
        else {if32.alu_c_out, if32.alu_sum} <= {1'b0, if32.alu_a} + {1'b0, if32.alu_b} + 33'(if32.alu_c_in);
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Carry entering word k of an 8-bit-word ADD, from the full-width arithmetic
    function automatic logic exp_cin8(input int k, input logic cmd, input logic [31:0] a,
                                      input logic [31:0] b, input logic cin);
        logic [63:0] mask, s;
        if (cmd) return 1'b0;
        mask = (64'd1 << (8*k)) - 64'd1;
        s = ({32'd0, a} & mask) + ({32'd0, b} & mask) + 64'(cin);
        return s[8*k];
    endfunction

    typedef struct {
        string       name;
        logic        cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] exp_res;
        logic        exp_c;
    } vec_t;

    task automatic issue8(input logic cmd, input logic [31:0] a, input logic [31:0] b, input logic cin);
        @(negedge clk);
        chk("issue_in_ready", 64'(if8.in_ready), 64'd1);
        if8.in_valid = 1'b1; if8.in_cmd = cmd; if8.in_a = a; if8.in_b = b; if8.in_cin = cin;
        @(negedge clk);
        if8.in_valid = 1'b0;
    endtask

    // Called at the first negedge after the accepting edge (word 0 being issued)
    task automatic wait_done8(input string name, input logic cmd, input logic [31:0] a,
                              input logic [31:0] b, input logic cin,
                              input logic [31:0] exp_res, input logic exp_c);
        int cnt = 0;
        while (!if8.out_valid && cnt < 20) begin
            if (cnt < 4) begin
                chk({name, "_alu_a"},   64'(if8.alu_a),    64'(a[8*cnt +: 8]));
                chk({name, "_alu_op"},  64'(if8.alu_op),   64'(cmd ? OP_NOT : OP_ADD));
                chk({name, "_alu_cin"}, 64'(if8.alu_c_in), 64'(exp_cin8(cnt, cmd, a, b, cin)));
            end
            @(negedge clk);
            cnt++;
        end
        chk({name, "_latency"}, 64'(cnt), 64'd5);
        chk({name, "_result"},  64'(if8.out_result), 64'(exp_res));
        chk({name, "_c_out"},   64'(if8.out_c_out),  64'(exp_c));
    endtask

    task automatic release8(input string name);
        if8.out_ready = 1'b1;
        @(negedge clk);
        if8.out_ready = 1'b0;
        chk({name, "_idle_in_ready"}, 64'(if8.in_ready), 64'd1);
        chk({name, "_idle_out_valid"}, 64'(if8.out_valid), 64'd0);
    endtask

    initial begin
        vec_t vecs[6];
        logic [31:0] held;
        int cnt;

        vecs[0] = '{"add_ff_1",    1'b0, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
        vecs[1] = '{"add_ripple",  1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
        vecs[2] = '{"not_a",       1'b1, 32'h12345678, 32'hFFFFFFFF, 1'b1, 32'hEDCBA987, 1'b0};
        vecs[3] = '{"add_top",     1'b0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
        vecs[4] = '{"add_mixed",   1'b0, 32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0};
        vecs[5] = '{"not_zero",    1'b1, 32'h00000000, 32'h5A5A5A5A, 1'b0, 32'hFFFFFFFF, 1'b0};

        rst_n = 1'b0;
        if8.in_valid = 0; if8.in_cmd = 0; if8.in_a = 0; if8.in_b = 0; if8.in_cin = 0; if8.out_ready = 0;
        if32.in_valid = 0; if32.in_cmd = 0; if32.in_a = 0; if32.in_b = 0; if32.in_cin = 0; if32.out_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  64'(if8.in_ready),   64'd1);
        chk("rst_out_valid", 64'(if8.out_valid),  64'd0);
        chk("rst_result",    64'(if8.out_result), 64'd0);
        chk("rst_c_out",     64'(if8.out_c_out),  64'd0);
        chk("rst_alu_op",    64'(if8.alu_op),     64'(OP_ADD));
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            issue8(vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].cin);
            wait_done8(vecs[i].name, vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].cin,
                       vecs[i].exp_res, vecs[i].exp_c);
            release8(vecs[i].name);
        end

        // Back-pressure in DONE with a stray in_valid pulse
        issue8(1'b0, 32'h0000FFFF, 32'h00000001, 1'b0);
        wait_done8("bp", 1'b0, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0);
        for (int k = 0; k < 3; k++) begin
            if8.in_valid = (k == 1); if8.in_a = 32'hDEADBEEF; if8.in_b = 32'h01010101;
            @(negedge clk);
            chk("bp_hold_result", 64'(if8.out_result), 64'h00010000);
            chk("bp_hold_c_out",  64'(if8.out_c_out),  64'd0);
            chk("bp_in_ready",    64'(if8.in_ready),   64'd0);
            chk("bp_out_valid",   64'(if8.out_valid),  64'd1);
        end
        if8.in_valid = 1'b0;
        release8("bp");
        repeat (3) @(negedge clk);
        chk("bp_stays_idle", 64'(if8.in_ready), 64'd1);
        chk("bp_no_start",   64'(if8.alu_a),    64'd0);

        // Asynchronous reset while issuing word 2
        issue8(1'b0, 32'h01020304, 32'h10203040, 1'b0);
        repeat (2) @(negedge clk);
        chk("mid_alu_a_idx2", 64'(if8.alu_a), 64'h02);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready",  64'(if8.in_ready),   64'd1);
        chk("mid_rst_out_valid", 64'(if8.out_valid),  64'd0);
        chk("mid_rst_result",    64'(if8.out_result), 64'd0);
        chk("mid_rst_c_out",     64'(if8.out_c_out),  64'd0);
        chk("mid_rst_alu_a",     64'(if8.alu_a),      64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue8(1'b0, 32'h00000001, 32'h00000001, 1'b0);
        wait_done8("post_rst", 1'b0, 32'h1, 32'h1, 1'b0, 32'h00000002, 1'b0);
        release8("post_rst");

        // Back-to-back with in_valid held high (8x4)
        @(negedge clk);
        if8.in_valid = 1'b1; if8.in_cmd = 1'b0; if8.in_a = 32'h00FF00FF; if8.in_b = 32'h00010001; if8.in_cin = 1'b0;
        @(negedge clk);
        if8.in_cmd = 1'b1; if8.in_a = 32'hF0F0F0F0; if8.in_b = 32'h0; if8.in_cin = 1'b1;
        wait_done8("b2b_first", 1'b0, 32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0);
        if8.out_ready = 1'b1;
        @(negedge clk);
        if8.out_ready = 1'b0;
        chk("b2b_gap_in_ready", 64'(if8.in_ready), 64'd1);
        @(negedge clk);
        if8.in_valid = 1'b0;
        wait_done8("b2b_second", 1'b1, 32'hF0F0F0F0, 32'h0, 1'b1, 32'h0F0F0F0F, 1'b0);
        release8("b2b_second");

        // Back-to-back on the 32x2 instance
        @(negedge clk);
        if32.in_valid = 1'b1; if32.in_cmd = 1'b0; if32.in_a = 64'hFFFFFFFF_FFFFFFFF;
        if32.in_b = 64'h1; if32.in_cin = 1'b0;
        @(negedge clk);
        if32.in_a = 64'h00000001_00000000; if32.in_b = 64'h00000000_FFFFFFFF; if32.in_cin = 1'b1;
        cnt = 0;
        while (!if32.out_valid && cnt < 20) begin
            if (cnt == 1) chk("w32_cin_word1", 64'(if32.alu_c_in), 64'd1);
            @(negedge clk); cnt++;
        end
        chk("w32_first_latency", 64'(cnt), 64'd3);
        chk("w32_first_result",  if32.out_result, 64'h0);
        chk("w32_first_c_out",   64'(if32.out_c_out), 64'd1);
        if32.out_ready = 1'b1;
        @(negedge clk);
        if32.out_ready = 1'b0;
        @(negedge clk);
        if32.in_valid = 1'b0;
        cnt = 0;
        while (!if32.out_valid && cnt < 20) begin
            @(negedge clk); cnt++;
        end
        chk("w32_second_latency", 64'(cnt), 64'd3);
        chk("w32_second_result",  if32.out_result, 64'h00000002_00000000);
        chk("w32_second_c_out",   64'(if32.out_c_out), 64'd0);
        held = if32.out_result[31:0];
        @(negedge clk);
        chk("w32_hold", 64'(if32.out_result[31:0]), 64'(held));
        if32.out_ready = 1'b1;
        @(negedge clk);
        if32.out_ready = 1'b0;
        chk("w32_idle", 64'(if32.in_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
